// File: rtl/hdb3_decoder.sv
// HDB3 receive decoder: removes 000V/B00V substitutions, recovers NRZ, flags line-code errors.
// Latency: bit k is registered out one accept after symbol k+4; in_valid=0 stalls all state but err_clr.
module hdb3_decoder #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [1:0]           polar_in,
    input  logic                 err_clr,
    output logic                 out_valid,
    output logic                 data_out,
    output logic                 err_illegal,
    output logic                 err_viol,
    output logic                 err_zeros,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [3:0]           s_q, s_d;
    logic [3:0]           v_q, v_d;
    logic                 last_pol_q, last_pol_d;
    logic                 have_pulse_q, have_pulse_d;
    logic                 last_v_pol_q, last_v_pol_d;
    logic                 have_v_q, have_v_d;
    logic [2:0]           zero_run_q, zero_run_d;
    logic                 out_valid_q, out_valid_d;
    logic                 data_out_q, data_out_d;
    logic                 err_illegal_q, err_illegal_d;
    logic                 err_viol_q, err_viol_d;
    logic                 err_zeros_q, err_zeros_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 sym_ill;
    logic                 sym_zero;
    logic                 sym_pulse;
    logic                 sym_pol;
    logic                 is_v;
    logic [1:0]           err_inc;
    logic [ERR_CNT_W:0]   cnt_sum;

    // polar_in[1] set means positive polarity; exactly one bit set is a legal pulse
    assign sym_ill   = (polar_in == 2'b11);
    assign sym_zero  = (polar_in == 2'b00);
    assign sym_pulse = polar_in[1] ^ polar_in[0];
    assign sym_pol   = polar_in[1];
    assign is_v      = sym_pulse && have_pulse_q && (sym_pol == last_pol_q);

    always_comb begin
        s_d           = s_q;
        v_d           = v_q;
        last_pol_d    = last_pol_q;
        have_pulse_d  = have_pulse_q;
        last_v_pol_d  = last_v_pol_q;
        have_v_d      = have_v_q;
        zero_run_d    = zero_run_q;
        out_valid_d   = 1'b0;
        data_out_d    = data_out_q;
        err_illegal_d = 1'b0;
        err_viol_d    = 1'b0;
        err_zeros_d   = 1'b0;

        if (in_valid) begin
            data_out_d  = s_q[3];
            out_valid_d = v_q[3];
            s_d         = {s_q[2:0], sym_pulse & ~is_v};
            v_d         = {v_q[2:0], 1'b1};
            // a violation marks the end of a 4-symbol substitution: zero it all
            if (is_v) begin
                s_d = '0;
            end

            if (sym_pulse) begin
                last_pol_d   = sym_pol;
                have_pulse_d = 1'b1;
                zero_run_d   = 3'd0;
            end else if (zero_run_q != 3'd4) begin
                zero_run_d = 3'(zero_run_q + 3'd1);
            end

            err_illegal_d = sym_ill;
            err_zeros_d   = sym_zero && (zero_run_q >= 3'd3);

            if (is_v) begin
                err_viol_d   = have_v_q && (sym_pol == last_v_pol_q);
                last_v_pol_d = sym_pol;
                have_v_d     = 1'b1;
            end
        end
    end

    // illegal and zero errors are mutually exclusive, so at most two events per accept
    always_comb begin
        err_inc = 2'({1'b0, err_illegal_d} + {1'b0, err_viol_d} + {1'b0, err_zeros_d});
        cnt_sum = {1'b0, err_cnt_q} + {{(ERR_CNT_W-1){1'b0}}, err_inc};
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (cnt_sum[ERR_CNT_W]) begin
            err_cnt_d = '1;
        end else begin
            err_cnt_d = cnt_sum[ERR_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q           <= '0;
            v_q           <= '0;
            last_pol_q    <= 1'b0;
            have_pulse_q  <= 1'b0;
            last_v_pol_q  <= 1'b0;
            have_v_q      <= 1'b0;
            zero_run_q    <= 3'd0;
            out_valid_q   <= 1'b0;
            data_out_q    <= 1'b0;
            err_illegal_q <= 1'b0;
            err_viol_q    <= 1'b0;
            err_zeros_q   <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            s_q           <= s_d;
            v_q           <= v_d;
            last_pol_q    <= last_pol_d;
            have_pulse_q  <= have_pulse_d;
            last_v_pol_q  <= last_v_pol_d;
            have_v_q      <= have_v_d;
            zero_run_q    <= zero_run_d;
            out_valid_q   <= out_valid_d;
            data_out_q    <= data_out_d;
            err_illegal_q <= err_illegal_d;
            err_viol_q    <= err_viol_d;
            err_zeros_q   <= err_zeros_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign data_out    = data_out_q;
    assign err_illegal = err_illegal_q;
    assign err_viol    = err_viol_q;
    assign err_zeros   = err_zeros_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_hdb3_decoder.sv
// Directed bench for hdb3_decoder; a second instance with a 2-bit counter covers saturation.
module tb_hdb3_decoder;

    localparam logic [1:0] P = 2'b10;
    localparam logic [1:0] N = 2'b01;
    localparam logic [1:0] Z = 2'b00;
    localparam logic [1:0] X = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  polar_in;
    logic        err_clr;
    logic        out_valid, data_out, err_illegal, err_viol, err_zeros;
    logic [15:0] err_cnt;
    logic        out_valid2, data_out2, err_illegal2, err_viol2, err_zeros2;
    logic [1:0]  err_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    hdb3_decoder #(.ERR_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .polar_in(polar_in),
        .err_clr(err_clr), .out_valid(out_valid), .data_out(data_out),
        .err_illegal(err_illegal), .err_viol(err_viol), .err_zeros(err_zeros),
        .err_cnt(err_cnt)
    );

    hdb3_decoder #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .polar_in(polar_in),
        .err_clr(err_clr), .out_valid(out_valid2), .data_out(data_out2),
        .err_illegal(err_illegal2), .err_viol(err_viol2), .err_zeros(err_zeros2),
        .err_cnt(err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // accept one symbol, then check registered outputs; err is {illegal, viol, zeros}
    task automatic acc(input string tag, input logic [1:0] sym, input logic ov,
                       input logic d, input logic [2:0] err);
        in_valid = 1'b1;
        polar_in = sym;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        polar_in = 2'b00;
        check({tag, "_ov"}, {31'd0, out_valid}, {31'd0, ov});
        if (ov) check({tag, "_do"}, {31'd0, data_out}, {31'd0, d});
        check({tag, "_err"}, {29'd0, err_illegal, err_viol, err_zeros}, {29'd0, err});
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_ov"},   {31'd0, out_valid}, 32'd0);
        check({tag, "_do"},   {31'd0, data_out}, 32'd0);
        check({tag, "_err"},  {29'd0, err_illegal, err_viol, err_zeros}, 32'd0);
        check({tag, "_cnt"},  {16'd0, err_cnt}, 32'd0);
        check({tag, "_cnt2"}, {30'd0, err_cnt2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        polar_in = 2'b00;
        err_clr  = 1'b0;
        #12;
        do_reset("init");

        // plain AMI, then alternating marks to drain
        acc("ami1", P, 0, 0, 3'b000);
        acc("ami2", N, 0, 0, 3'b000);
        acc("ami3", Z, 0, 0, 3'b000);
        acc("ami4", P, 0, 0, 3'b000);
        acc("ami5", Z, 1, 1, 3'b000);
        acc("ami6", N, 1, 1, 3'b000);
        acc("ami7", P, 1, 0, 3'b000);
        acc("ami8", N, 1, 1, 3'b000);
        acc("ami9", P, 1, 0, 3'b000);
        acc("ami10", N, 1, 1, 3'b000);
        acc("ami11", P, 1, 1, 3'b000);
        acc("ami12", N, 1, 1, 3'b000);
        check("ami_cnt", {16'd0, err_cnt}, 32'd0);

        do_reset("rst_a");
        // 000V: fifth symbol is the violation
        acc("v1", P, 0, 0, 3'b000);
        acc("v2", Z, 0, 0, 3'b000);
        acc("v3", Z, 0, 0, 3'b000);
        acc("v4", Z, 0, 0, 3'b000);
        acc("v5", P, 1, 1, 3'b000);
        acc("v6", N, 1, 0, 3'b000);
        acc("v7", Z, 1, 0, 3'b000);
        acc("v8", Z, 1, 0, 3'b000);
        acc("v9", Z, 1, 0, 3'b000);
        acc("v10", P, 1, 1, 3'b000);
        acc("v11", N, 1, 0, 3'b000);
        acc("v12", P, 1, 0, 3'b000);
        acc("v13", N, 1, 0, 3'b000);
        check("v_cnt", {16'd0, err_cnt}, 32'd0);

        do_reset("rst_b");
        // B00V: second symbol is B, removed by the V on the fifth
        acc("b1", P, 0, 0, 3'b000);
        acc("b2", N, 0, 0, 3'b000);
        acc("b3", Z, 0, 0, 3'b000);
        acc("b4", Z, 0, 0, 3'b000);
        acc("b5", N, 1, 1, 3'b000);
        acc("b6", P, 1, 0, 3'b000);
        acc("b7", N, 1, 0, 3'b000);
        acc("b8", P, 1, 0, 3'b000);
        acc("b9", N, 1, 0, 3'b000);
        acc("b10", P, 1, 1, 3'b000);
        // V (+) alternates with previous V (-); next V (+) repeats polarity
        acc("c11", P, 1, 1, 3'b000);
        acc("c12", N, 1, 0, 3'b000);
        acc("c13", P, 1, 0, 3'b000);
        acc("c14", P, 1, 0, 3'b010);
        check("c_cnt", {16'd0, err_cnt}, 32'd1);
        acc("c15", N, 1, 0, 3'b000);
        acc("c16", P, 1, 0, 3'b000);
        acc("c17", N, 1, 0, 3'b000);
        acc("c18", P, 1, 0, 3'b000);
        // illegal symbol keeps last_pol, so the following N is a mark
        acc("i19", X, 1, 1, 3'b100);
        check("i_cnt", {16'd0, err_cnt}, 32'd2);
        acc("i20", N, 1, 1, 3'b000);
        acc("i21", P, 1, 1, 3'b000);
        acc("i22", N, 1, 1, 3'b000);
        acc("i23", P, 1, 0, 3'b000);
        check("i_cnt2", {16'd0, err_cnt}, 32'd2);

        do_reset("rst_c");
        acc("z1", Z, 0, 0, 3'b000);
        acc("z2", Z, 0, 0, 3'b000);
        acc("z3", Z, 0, 0, 3'b000);
        acc("z4", Z, 0, 0, 3'b001);
        acc("z5", Z, 1, 0, 3'b001);
        check("z_cnt", {16'd0, err_cnt}, 32'd2);
        acc("z6", P, 1, 0, 3'b000);

        do_reset("rst_d");
        acc("x1", X, 0, 0, 3'b100);
        acc("x2", X, 0, 0, 3'b100);
        acc("x3", X, 0, 0, 3'b100);
        check("x3_cnt2", {30'd0, err_cnt2}, 32'd3);
        acc("x4", X, 0, 0, 3'b100);
        acc("x5", X, 1, 0, 3'b100);
        check("x5_cnt", {16'd0, err_cnt}, 32'd5);
        check("x5_cnt2", {30'd0, err_cnt2}, 32'd3);
        err_clr = 1'b1;
        acc("x6", X, 1, 0, 3'b100);
        err_clr = 1'b0;
        check("clr_cnt", {16'd0, err_cnt}, 32'd0);
        check("clr_cnt2", {30'd0, err_cnt2}, 32'd0);

        do_reset("rst_e");
        acc("h1", P, 0, 0, 3'b000);
        acc("h2", N, 0, 0, 3'b000);
        acc("h3", P, 0, 0, 3'b000);
        acc("h4", N, 0, 0, 3'b000);
        repeat (10) @(posedge clk);
        #1;
        check("idle_ov", {31'd0, out_valid}, 32'd0);
        check("idle_err", {29'd0, err_illegal, err_viol, err_zeros}, 32'd0);
        acc("h5", P, 1, 1, 3'b000);
        acc("h6", X, 1, 1, 3'b100);
        check("h_cnt", {16'd0, err_cnt}, 32'd1);

        // asynchronous reset mid-cycle; first P afterwards must decode as a mark
        do_reset("rst_mid");
        acc("r1", P, 0, 0, 3'b000);
        acc("r2", N, 0, 0, 3'b000);
        acc("r3", P, 0, 0, 3'b000);
        acc("r4", N, 0, 0, 3'b000);
        acc("r5", P, 1, 1, 3'b000);
        acc("r6", N, 1, 1, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
